rf_sb: RTL and testbench



---
 rtl/rf_sb.sv | 121 ++++++++++++
 tb/tb_rf_sb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sb.sv
// rf_sb: parametrised register file with a per-register busy scoreboard.
// Two combinational read ports, one synchronous write port, and a
// reserve port used by decode to mark registers with in-flight writes.
// Writeback writes a register and releases its busy bit in the same edge.
// Optional build macro: RF_SB_BYPASS_EN forwards a same-cycle write to the
// read ports (data and busy); storage, scoreboard, busycnt and err are
// the same in both builds.
module rf_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1regsel,
  input  logic [ADDR_W-1:0] read2regsel,
  input  logic [ADDR_W-1:0] writeregsel,
  input  logic [DATA_W-1:0] writedata,
  input  logic              write,
  input  logic              resv,
  input  logic [ADDR_W-1:0] resvregsel,
  output logic [DATA_W-1:0] read1data,
  output logic [DATA_W-1:0] read2data,
  output logic              read1busy,
  output logic              read2busy,
  output logic [ADDR_W:0]   busycnt,
  output logic              err
);

  // NREGS <= 2**ADDR_W, so it always fits in ADDR_W+1 bits.
  localparam logic [ADDR_W:0] NREGS_W = (ADDR_W+1)'(NREGS);

  logic [DATA_W-1:0] regs [0:NREGS-1];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic r1_ok, r2_ok, wr_in, rv_in, wr_ok, rv_ok, release_hit;

  // Range decode of every select; out-of-range selects never touch state.
  always_comb begin
    r1_ok = ({1'b0, read1regsel} < NREGS_W);
    r2_ok = ({1'b0, read2regsel} < NREGS_W);
    wr_in = ({1'b0, writeregsel} < NREGS_W);
    rv_in = ({1'b0, resvregsel}  < NREGS_W);
    wr_ok = write && wr_in;
    rv_ok = resv && rv_in;
    // A reservation is allowed on a busy register only if writeback
    // releases that same register in this cycle.
    release_hit = wr_ok && (writeregsel == resvregsel);
  end

  // Illegal operations this cycle: out-of-range write/reserve, or a
  // reservation of a register that is still busy and not being released.
  always_comb begin
    err = 1'b0;
    if (!rst) begin
      if (write && !wr_in)
        err = 1'b1;
      if (resv && !rv_in)
        err = 1'b1;
      if (rv_ok && busy[resvregsel] && !release_hit)
        err = 1'b1;
    end
  end

  // Next scoreboard: release first, then reserve, so a same-register
  // reserve wins over the release. Population count feeds busycnt.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[writeregsel] = 1'b0;
    if (rv_ok)
      busy_nxt[resvregsel] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  // Storage, scoreboard and busy count; reset overrides write and resv.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy    <= '0;
      busycnt <= '0;
    end else begin
      if (wr_ok)
        regs[writeregsel] <= writedata;
      busy    <= busy_nxt;
      busycnt <= cnt_nxt;
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    read1data = '0;
    read2data = '0;
    read1busy = 1'b0;
    read2busy = 1'b0;
    if (r1_ok) begin
      read1data = regs[read1regsel];
      read1busy = busy[read1regsel];
    end
    if (r2_ok) begin
      read2data = regs[read2regsel];
      read2busy = busy[read2regsel];
    end
`ifdef RF_SB_BYPASS_EN
    if (wr_ok && r1_ok && (writeregsel == read1regsel)) begin
      read1data = writedata;
      read1busy = rv_ok && (resvregsel == read1regsel);
    end
    if (wr_ok && r2_ok && (writeregsel == read2regsel)) begin
      read2data = writedata;
      read2busy = rv_ok && (resvregsel == read2regsel);
    end
`endif
  end

endmodule

// File: tb/tb_rf_sb.sv
// tb_rf_sb: self-checking bench for rf_sb, built with NREGS=6 so that
// selects 6 and 7 exercise the out-of-range paths. Directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_rf_sb;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read1regsel, read2regsel, writeregsel, resvregsel;
  logic [DW-1:0] writedata;
  logic          write, resv;
  logic [DW-1:0] read1data, read2data;
  logic          read1busy, read2busy;
  logic [AW:0]   busycnt;
  logic          err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: register contents and busy flags after each edge.
  logic [DW-1:0] m_mem [NR];
  bit            m_bsy [NR];

  rf_sb #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst),
    .read1regsel(read1regsel), .read2regsel(read2regsel),
    .writeregsel(writeregsel), .writedata(writedata), .write(write),
    .resv(resv), .resvregsel(resvregsel),
    .read1data(read1data), .read2data(read2data),
    .read1busy(read1busy), .read2busy(read2busy),
    .busycnt(busycnt), .err(err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) c += m_bsy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [DW-1:0] m_rdata(int sel);
    if (sel >= NR) return '0;
`ifdef RF_SB_BYPASS_EN
    if (write && int'(writeregsel) == sel) return writedata;
`endif
    return m_mem[sel];
  endfunction

  function automatic logic m_rbusy(int sel);
    if (sel >= NR) return 1'b0;
`ifdef RF_SB_BYPASS_EN
    if (write && int'(writeregsel) == sel)
      return resv && int'(resvregsel) == sel;
`endif
    return m_bsy[sel];
  endfunction

  function automatic logic m_err();
    int ws = int'(writeregsel);
    int rs = int'(resvregsel);
    if (rst) return 1'b0;
    if (write && ws >= NR) return 1'b1;
    if (resv && rs >= NR) return 1'b1;
    if (resv && m_bsy[rs] && !(write && ws == rs)) return 1'b1;
    return 1'b0;
  endfunction

  // Driver tasks
  task automatic idle();
    rst = 1'b0; write = 1'b0; resv = 1'b0;
    writeregsel = '0; resvregsel = '0; writedata = '0;
  endtask

  task automatic drive_wr(int sel, logic [DW-1:0] d);
    write = 1'b1; writeregsel = AW'(sel); writedata = d;
  endtask

  task automatic drive_rv(int sel);
    resv = 1'b1; resvregsel = AW'(sel);
  endtask

  // Advance one edge, update the model from the inputs held at that edge,
  // then leave inputs free to change 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_bsy[i] = 0; end
    end else begin
      if (write && int'(writeregsel) < NR) begin
        m_mem[writeregsel] = writedata;
        m_bsy[writeregsel] = 0;
      end
      if (resv && int'(resvregsel) < NR) m_bsy[resvregsel] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    drive_wr(7, 16'hFFFF);
    drive_rv(6);
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err_forced got=%b exp=0", err); end
    step();
    idle();
    read1regsel = 3'd0; read2regsel = 3'd3;
    #2;
    checks++;
    if (busycnt !== 4'd0) begin errors++; $display("FAIL reset_busycnt got=%0d exp=0", busycnt); end
    checks++;
    if (read1data !== 16'h0 || read2data !== 16'h0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0000/0000", read1data, read2data);
    end
    checks++;
    if (read1busy !== 1'b0 || read2busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got busy=%b%b err=%b exp=000", read1busy, read2busy, err);
    end
  endtask

  task automatic test_write_read();
    idle();
    drive_wr(3, 16'hABCD);
    step();
    idle();
    read1regsel = 3'd3; read2regsel = 3'd3;
    #2;
    checks++;
    if (read1data !== 16'hABCD || read2data !== 16'hABCD) begin
      errors++; $display("FAIL write_read_data got=%h/%h exp=abcd/abcd", read1data, read2data);
    end
    checks++;
    if (read1busy !== 1'b0 || read2busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL write_read_flags got busy=%b%b err=%b exp=000", read1busy, read2busy, err);
    end
    read1regsel = 3'd0; read2regsel = 3'd5;
    #1;
    checks++;
    if (read1data !== 16'h0 || read2data !== 16'h0) begin
      errors++; $display("FAIL write_read_others got=%h/%h exp=0000/0000", read1data, read2data);
    end
  endtask

  task automatic test_reserve_release();
    idle();
    drive_rv(5);
    step();
    idle();
    read1regsel = 3'd5;
    #2;
    checks++;
    if (read1busy !== 1'b1 || busycnt !== 4'd1) begin
      errors++; $display("FAIL reserve_busy got busy=%b cnt=%0d exp busy=1 cnt=1", read1busy, busycnt);
    end
    drive_wr(5, 16'h1234);
    step();
    idle();
    read1regsel = 3'd5;
    #2;
    checks++;
    if (read1busy !== 1'b0 || busycnt !== 4'd0 || read1data !== 16'h1234) begin
      errors++; $display("FAIL release got busy=%b cnt=%0d data=%h exp busy=0 cnt=0 data=1234",
                         read1busy, busycnt, read1data);
    end
  endtask

  task automatic test_double_reserve();
    idle();
    drive_rv(2);
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL double_resv_first_err got=%b exp=0", err); end
    step();
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL double_resv_second_err got=%b exp=1", err); end
    step();
    idle();
    read1regsel = 3'd2;
    #2;
    checks++;
    if (err !== 1'b0 || read1busy !== 1'b1 || busycnt !== 4'd1) begin
      errors++; $display("FAIL double_resv_after got err=%b busy=%b cnt=%0d exp err=0 busy=1 cnt=1",
                         err, read1busy, busycnt);
    end
  endtask

  task automatic test_write_resv_same();
    idle();
    drive_rv(4);
    step();
    idle();
    drive_wr(4, 16'h00FF);
    drive_rv(4);
    #2;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL same_reg_err got=%b exp=0", err); end
    step();
    idle();
    read1regsel = 3'd4;
    #2;
    checks++;
    if (read1data !== 16'h00FF || read1busy !== 1'b1 || busycnt !== 4'd2) begin
      errors++; $display("FAIL same_reg_state got data=%h busy=%b cnt=%0d exp data=00ff busy=1 cnt=2",
                         read1data, read1busy, busycnt);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    drive_wr(7, 16'hFFFF);
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err got=%b exp=1", err); end
    step();
    idle();
    for (int i = 0; i < NR; i++) begin
      read1regsel = AW'(i);
      #1;
      checks++;
      if (read1data !== m_mem[i]) begin
        errors++; $display("FAIL oor_write_reg%0d got=%h exp=%h", i, read1data, m_mem[i]);
      end
    end
    read2regsel = 3'd6;
    drive_rv(6);
    #1;
    checks++;
    if (read2data !== 16'h0 || read2busy !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL oor_read_resv got data=%h busy=%b err=%b exp data=0000 busy=0 err=1",
                         read2data, read2busy, err);
    end
    step();
    idle();
    #2;
    checks++;
    if (busycnt !== 4'd2) begin errors++; $display("FAIL oor_resv_cnt got=%0d exp=2", busycnt); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp;
    idle();
    read1regsel = 3'd1;
    drive_wr(1, 16'h5555);
`ifdef RF_SB_BYPASS_EN
    exp = 16'h5555;
`else
    exp = 16'h0000;
`endif
    #2;
    checks++;
    if (read1data !== exp) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", read1data, exp); end
    step();
    idle();
    #2;
    checks++;
    if (read1data !== 16'h5555) begin errors++; $display("FAIL bypass_next_cycle got=%h exp=5555", read1data); end
  endtask

  task automatic test_reset_busy();
    idle();
    rst = 1'b1;
    step();
    idle();
    drive_rv(0); step();
    drive_rv(1); step();
    drive_rv(3); step();
    idle();
    #2;
    checks++;
    if (busycnt !== 4'd3) begin errors++; $display("FAIL rst_busy_pre_cnt got=%0d exp=3", busycnt); end
    rst = 1'b1;
    drive_wr(0, 16'hBEEF);
    drive_rv(4);
    step();
    idle();
    #2;
    checks++;
    if (busycnt !== 4'd0) begin errors++; $display("FAIL rst_busy_cnt got=%0d exp=0", busycnt); end
    for (int i = 0; i < NR; i++) begin
      read1regsel = AW'(i);
      #1;
      checks++;
      if (read1busy !== 1'b0 || read1data !== 16'h0) begin
        errors++; $display("FAIL rst_busy_reg%0d got busy=%b data=%h exp busy=0 data=0000", i, read1busy, read1data);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      write       = $urandom_range(0, 1);
      resv        = $urandom_range(0, 2) == 0;
      writeregsel = AW'($urandom_range(0, 7));
      resvregsel  = ($urandom_range(0, 3) == 0) ? writeregsel : AW'($urandom_range(0, 7));
      writedata   = DW'($urandom);
      read1regsel = ($urandom_range(0, 3) == 0) ? writeregsel : AW'($urandom_range(0, 7));
      read2regsel = AW'($urandom_range(0, 7));
      #2;
      checks++;
      if (err !== m_err()) begin errors++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, m_err()); end
      checks++;
      if (read1data !== m_rdata(read1regsel) || read1busy !== m_rbusy(read1regsel)) begin
        errors++; $display("FAIL rand_port1 n=%0d sel=%0d got=%h/%b exp=%h/%b", n, read1regsel,
                           read1data, read1busy, m_rdata(read1regsel), m_rbusy(read1regsel));
      end
      checks++;
      if (read2data !== m_rdata(read2regsel) || read2busy !== m_rbusy(read2regsel)) begin
        errors++; $display("FAIL rand_port2 n=%0d sel=%0d got=%h/%b exp=%h/%b", n, read2regsel,
                           read2data, read2busy, m_rdata(read2regsel), m_rbusy(read2regsel));
      end
      checks++;
      if (int'(busycnt) != m_cnt()) begin
        errors++; $display("FAIL rand_busycnt n=%0d got=%0d exp=%0d", n, busycnt, m_cnt());
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    read1regsel = '0;
    read2regsel = '0;
    for (int i = 0; i < NR; i++) begin m_mem[i] = '0; m_bsy[i] = 0; end
    #1;
    test_reset();
    test_write_read();
    test_reserve_release();
    test_double_reserve();
    test_write_resv_same();
    test_out_of_range();
    test_bypass();
    test_reset_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
